// File: rtl/reg_file_nxw_if.sv
// reg_file_nxw_if: write port, two read ports and clear-sweep handshake of reg_file_nxw.
// The master side drives requests and addresses; the slave side is the register file.
interface reg_file_nxw_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
);
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [WIDTH-1:0]  write_data;
    logic [ADDR_W-1:0] read_addr_1;
    logic [ADDR_W-1:0] read_addr_2;
    logic [WIDTH-1:0]  read_data_1;
    logic [WIDTH-1:0]  read_data_2;
    logic              clear_req;
    logic              clear_busy;
    logic [DEPTH-1:0]  written_mask;

    modport master (
        output write_en, write_addr, write_data, read_addr_1, read_addr_2, clear_req,
        input  read_data_1, read_data_2, clear_busy, written_mask
    );

    modport slave (
        input  write_en, write_addr, write_data, read_addr_1, read_addr_2, clear_req,
        output read_data_1, read_data_2, clear_busy, written_mask
    );
endinterface

// File: rtl/reg_file_nxw.sv
// reg_file_nxw: DEPTH x WIDTH register file, one write port, two combinational read ports,
// per-word written mask and a one-word-per-cycle clear sweep that blocks writes while busy.
// Optional macro REG_FILE_WRITE_BYPASS_EN: forward an accepted write to matching read ports
// in the same cycle (write-first); without it reads are read-first.
module reg_file_nxw #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_nxw_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]  mask_q;
    logic              wr_in_range;
    logic              wr_accept;
    logic              sweep_last;

    assign wr_in_range = 32'(bus.write_addr) < DEPTH;
    // Writes are refused for the whole sweep, not queued.
    assign wr_accept   = bus.write_en && (state_q == StIdle) && wr_in_range;
    assign sweep_last  = (ptr_q == ADDR_W'(DEPTH - 1));

    // Clear FSM next state and sweep pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clear_req) begin
                    state_d = StSweep;
                    ptr_d   = '0;
                end
            end
            StSweep: begin
                // clear_req is ignored here so the sweep is never restarted or extended.
                if (sweep_last) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                ptr_d   = '0;
            end
        endcase
    end

    // FSM state and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Word storage and written mask: sweep clears one word per cycle, else accepted write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            mask_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((state_q == StSweep) && (ptr_q == ADDR_W'(i))) begin
                    mem_q[i]  <= '0;
                    mask_q[i] <= 1'b0;
                end else if (wr_accept && (bus.write_addr == ADDR_W'(i))) begin
                    mem_q[i]  <= bus.write_data;
                    mask_q[i] <= 1'b1;
                end
            end
        end
    end

    // Read port 1: out-of-range addresses read zero.
    always_comb begin
        bus.read_data_1 = '0;
        if (32'(bus.read_addr_1) < DEPTH) begin
            bus.read_data_1 = mem_q[bus.read_addr_1];
        end
`ifdef REG_FILE_WRITE_BYPASS_EN
        if (wr_accept && (bus.read_addr_1 == bus.write_addr)) begin
            bus.read_data_1 = bus.write_data;
        end
`endif
    end

    // Read port 2: identical to port 1, fully independent.
    always_comb begin
        bus.read_data_2 = '0;
        if (32'(bus.read_addr_2) < DEPTH) begin
            bus.read_data_2 = mem_q[bus.read_addr_2];
        end
`ifdef REG_FILE_WRITE_BYPASS_EN
        if (wr_accept && (bus.read_addr_2 == bus.write_addr)) begin
            bus.read_data_2 = bus.write_data;
        end
`endif
    end

    assign bus.clear_busy   = (state_q == StSweep);
    assign bus.written_mask = mask_q;
endmodule

// File: tb/tb_reg_file_nxw.sv
// tb_reg_file_nxw: directed table, async-reset-mid-sweep sequence and randomized run
// against a behavioural model of reg_file_nxw (WIDTH=8, DEPTH=4, ADDR_W=2).
module tb_reg_file_nxw;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 2;
`ifdef REG_FILE_WRITE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    reg_file_nxw_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    reg_file_nxw #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic [1:0] waddr;
        logic [7:0] wdata;
        logic [1:0] ra1;
        logic [1:0] ra2;
        logic       clr;
        logic [7:0] exp_rd1;
        logic [7:0] exp_rd2;
        logic       exp_busy;
        logic [3:0] exp_mask;
    } vec_t;

    vec_t vecs [21];

    // Behavioural model: word array, mask bits, and remaining sweep cycles (0 = idle).
    logic [7:0] m_mem  [DEPTH];
    bit         m_mask [DEPTH];
    int         sweep_left;

    function automatic vec_t mk(logic we, logic [1:0] wa, logic [7:0] wd, logic [1:0] ra1,
                                logic [1:0] ra2, logic clr, logic [7:0] e1, logic [7:0] e2,
                                logic eb, logic [3:0] em);
        vec_t v;
        v.we = we; v.waddr = wa; v.wdata = wd; v.ra1 = ra1; v.ra2 = ra2; v.clr = clr;
        v.exp_rd1 = e1; v.exp_rd2 = e2; v.exp_busy = eb; v.exp_mask = em;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic we, logic [1:0] wa, logic [7:0] wd, logic [1:0] ra1,
                         logic [1:0] ra2, logic clr);
        bus.write_en    = we;
        bus.write_addr  = wa;
        bus.write_data  = wd;
        bus.read_addr_1 = ra1;
        bus.read_addr_2 = ra2;
        bus.clear_req   = clr;
    endtask

    task automatic m_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_mem[i]  = 8'h00;
            m_mask[i] = 1'b0;
        end
        sweep_left = 0;
    endtask

    function automatic logic [7:0] m_read(logic [1:0] a);
        if (int'(a) >= int'(DEPTH)) return 8'h00;
        if (Bypass && bus.write_en && sweep_left == 0 && int'(bus.write_addr) < int'(DEPTH)
            && a == bus.write_addr) return bus.write_data;
        return m_mem[a];
    endfunction

    function automatic logic [3:0] m_mask_vec();
        logic [3:0] m;
        for (int i = 0; i < int'(DEPTH); i++) m[i] = m_mask[i];
        return m;
    endfunction

    // Applies one clock edge of the current inputs to the model.
    task automatic m_edge();
        int idx;
        if (sweep_left > 0) begin
            idx = int'(DEPTH) - sweep_left;
            m_mem[idx]  = 8'h00;
            m_mask[idx] = 1'b0;
            sweep_left--;
        end else begin
            if (bus.write_en && int'(bus.write_addr) < int'(DEPTH)) begin
                m_mem[bus.write_addr]  = bus.write_data;
                m_mask[bus.write_addr] = 1'b1;
            end
            if (bus.clear_req) sweep_left = int'(DEPTH);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("reset_rd1", int'(bus.read_data_1), 0);
        chk("reset_rd2", int'(bus.read_data_2), 0);
        chk("reset_busy", int'(bus.clear_busy), 0);
        chk("reset_mask", int'(bus.written_mask), 0);
        #9 reset = 1'b0;
        @(posedge clk);
        #1;

        //          we  wa  wdata  ra1 ra2 clr  exp_rd1                 exp_rd2  busy mask
        vecs[0]  = mk(1, 2, 8'hA5, 2, 1, 0, Bypass ? 8'hA5 : 8'h00, 8'h00, 0, 4'b0000);
        vecs[1]  = mk(1, 1, 8'h3C, 2, 1, 0, 8'hA5, Bypass ? 8'h3C : 8'h00, 0, 4'b0100);
        vecs[2]  = mk(0, 0, 8'h00, 2, 1, 0, 8'hA5, 8'h3C, 0, 4'b0110);
        vecs[3]  = mk(1, 3, 8'h77, 3, 2, 0, Bypass ? 8'h77 : 8'h00, 8'hA5, 0, 4'b0110);
        vecs[4]  = mk(0, 0, 8'h00, 3, 3, 0, 8'h77, 8'h77, 0, 4'b1110);
        vecs[5]  = mk(1, 0, 8'h11, 0, 3, 0, Bypass ? 8'h11 : 8'h00, 8'h77, 0, 4'b1110);
        vecs[6]  = mk(1, 1, 8'h22, 1, 0, 0, Bypass ? 8'h22 : 8'h3C, 8'h11, 0, 4'b1111);
        vecs[7]  = mk(1, 2, 8'h33, 2, 1, 0, Bypass ? 8'h33 : 8'hA5, 8'h22, 0, 4'b1111);
        vecs[8]  = mk(1, 3, 8'h44, 3, 2, 0, Bypass ? 8'h44 : 8'h77, 8'h33, 0, 4'b1111);
        vecs[9]  = mk(0, 0, 8'h00, 0, 3, 1, 8'h11, 8'h44, 0, 4'b1111);
        vecs[10] = mk(0, 0, 8'h00, 0, 3, 0, 8'h11, 8'h44, 1, 4'b1111);
        vecs[11] = mk(1, 3, 8'hFF, 0, 3, 1, 8'h00, 8'h44, 1, 4'b1110);
        vecs[12] = mk(1, 3, 8'hFF, 1, 3, 1, 8'h00, 8'h44, 1, 4'b1100);
        vecs[13] = mk(0, 0, 8'h00, 2, 3, 0, 8'h00, 8'h44, 1, 4'b1000);
        vecs[14] = mk(0, 0, 8'h00, 3, 0, 0, 8'h00, 8'h00, 0, 4'b0000);
        vecs[15] = mk(1, 0, 8'h5A, 0, 1, 1, Bypass ? 8'h5A : 8'h00, 8'h00, 0, 4'b0000);
        vecs[16] = mk(0, 0, 8'h00, 0, 0, 0, 8'h5A, 8'h5A, 1, 4'b0001);
        vecs[17] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 4'b0000);
        vecs[18] = mk(0, 0, 8'h00, 1, 2, 0, 8'h00, 8'h00, 1, 4'b0000);
        vecs[19] = mk(0, 0, 8'h00, 3, 0, 0, 8'h00, 8'h00, 1, 4'b0000);
        vecs[20] = mk(1, 2, 8'h66, 2, 3, 0, Bypass ? 8'h66 : 8'h00, 8'h00, 0, 4'b0000);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ra1, vecs[i].ra2,
                  vecs[i].clr);
            @(negedge clk);
            chk($sformatf("vec%0d_rd1", i), int'(bus.read_data_1), int'(vecs[i].exp_rd1));
            chk($sformatf("vec%0d_rd2", i), int'(bus.read_data_2), int'(vecs[i].exp_rd2));
            chk($sformatf("vec%0d_busy", i), int'(bus.clear_busy), int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_mask", i), int'(bus.written_mask), int'(vecs[i].exp_mask));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the second sweep cycle.
        drive(1'b1, 2'd1, 8'h9C, 2'd3, 2'd1, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 2'd3, 8'hE7, 2'd3, 2'd1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 2'd0, 8'h00, 2'd3, 2'd1, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 2'd0, 8'h00, 2'd3, 2'd1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("midsweep_busy", int'(bus.clear_busy), 1);
        chk("midsweep_rd1", int'(bus.read_data_1), 'hE7);
        chk("midsweep_rd2", int'(bus.read_data_2), 'h9C);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", int'(bus.clear_busy), 0);
        chk("async_rst_mask", int'(bus.written_mask), 0);
        chk("async_rst_rd1", int'(bus.read_data_1), 0);
        chk("async_rst_rd2", int'(bus.read_data_2), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_busy", int'(bus.clear_busy), 0);
        chk("post_rst_mask", int'(bus.written_mask), 0);
        @(posedge clk);
        #1;

        // Randomized run against the model, starting from the reset state.
        m_reset();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 2'($urandom),
                  2'($urandom), ($urandom_range(0, 7) == 0));
            @(negedge clk);
            chk("rand_rd1", int'(bus.read_data_1), int'(m_read(bus.read_addr_1)));
            chk("rand_rd2", int'(bus.read_data_2), int'(m_read(bus.read_addr_2)));
            chk("rand_busy", int'(bus.clear_busy), int'(sweep_left > 0));
            chk("rand_mask", int'(bus.written_mask), int'(m_mask_vec()));
            m_edge();
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file_nxw.md
Name: reg_file_nxw

Overview:
- Parametrised register file: DEPTH words of WIDTH bits, one write port, two independent combinational read ports.
- Successor to the fixed 2-bit, single-word RAM cells used in the lab datapath, and serves as the datapath register bank.
- Adds an address-decoded write, a per-word written-status mask, and a sequential clear-sweep engine with a busy handshake.

Parameters:
- WIDTH, 8, bits per word (>=1)
- DEPTH, 4, number of words (>=2)
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- write_en  input  1  write request for the current cycle
- write_addr  input  ADDR_W  target word of the write
- write_data  input  WIDTH  data to store
- read_addr_1  input  ADDR_W  read port 1 address
- read_addr_2  input  ADDR_W  read port 2 address
- read_data_1  output  WIDTH  read port 1 data, combinational
- read_data_2  output  WIDTH  read port 2 data, combinational
- clear_req  input  1  one-cycle request to start a clear sweep
- clear_busy  output  1  high while the sweep runs; writes are refused
- written_mask  output  DEPTH  bit i set once word i has been written since the last reset or clear

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset, applied asynchronously:
  - all words = 0, written_mask = 0, clear_busy = 0;
  - FSM = IDLE, sweep pointer = 0;
  - read_data_1/2 therefore read 0.
- Write:
  - Accepted at a rising edge when write_en=1, clear_busy=0 and write_addr < DEPTH.
  - Effect: word[write_addr] <= write_data and written_mask[write_addr] <= 1. Latency is 1 cycle.
  - write_addr >= DEPTH: write ignored, no state change.
  - Writes while clear_busy=1 are dropped silently and are not queued.
- Read:
  - read_data_n = word[read_addr_n]; returns 0 when read_addr_n >= DEPTH.
  - The two ports are fully independent; the same address on both ports returns the same data.
- Clear FSM, two states:
  - IDLE: clear_busy=0. On clear_req=1 at an edge, go to SWEEP with pointer=0.
  - SWEEP: clear_busy=1. Each edge sets word[pointer] <= 0, clears written_mask[pointer], and increments pointer. At the edge where pointer==DEPTH-1, return to IDLE with pointer=0.
  - The sweep therefore occupies exactly DEPTH cycles, with clear_busy high for DEPTH cycles.
  - clear_req while in SWEEP is ignored and does not restart or extend the sweep.
- Simultaneous clear_req and an accepted write in IDLE:
  - the write is performed at that edge;
  - the sweep then starts and zeroes that word in its turn.
- Reads during SWEEP return live contents: already-swept words read 0, the rest keep their values.
- Reset asserted mid-sweep: immediate return to the reset state; clear_busy drops asynchronously.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined: for an accepted write (write_en=1, clear_busy=0, write_addr<DEPTH), any read port whose address equals write_addr returns write_data combinationally in the same cycle, i.e. write-first forwarding.
- Not defined: such a read returns the old stored value until the next cycle, i.e. read-first.
- In both builds, refused writes (busy or out of range) are never forwarded.

Test Plan (WIDTH=8, DEPTH=4, ADDR_W=2):
1. Reset, then write 0xA5 to addr 2 and 0x3C to addr 1 -> next cycle read_addr_1=2 gives 0xA5, read_addr_2=1 gives 0x3C; written_mask=4'b0110.
2. Write 0x77 to addr 3 with read_addr_1=3 in the same cycle -> same-cycle read is 0x77 with REG_FILE_WRITE_BYPASS_EN, else the prior value 0x00; both builds read 0x77 the following cycle.
3. Words hold 0x11/0x22/0x33/0x44; pulse clear_req -> clear_busy high for exactly 4 cycles. After the first edge word0 reads 0x00 while word3 still reads 0x44. After 4 edges all words read 0 and written_mask=0.
4. During the sweep, assert write_en to addr 3 with 0xFF and pulse clear_req again -> write dropped, sweep still ends after 4 cycles, word3 = 0x00.
5. Same-edge clear_req plus write 0x5A to addr 0 in IDLE -> word0 = 0x5A for one cycle, then 0x00 after the first sweep edge.
6. Assert reset asynchronously mid-sweep (between edges, second cycle) -> clear_busy, written_mask and all read data go to 0 immediately, without waiting for clk.
